rv_muldiv_unit: RTL and testbench

Parametrised, iterative multiply/divide unit that extends the single-cycle RV32I ALU with the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the ALU in the execute stage. The core issues one operation through a start/busy/done handshake and stalls until `done`. Operands are processed one bit per cycle, so area stays small for any `XLEN`.

---
 rtl/rv_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// One bit of the multiplier (or one quotient bit) is processed per cycle, so a
// normal operation takes XLEN+2 cycles from accept to done. Divide-by-zero and
// signed overflow finish in one cycle with the architecturally defined value.
//
// Handshake: start is sampled only in IDLE; busy is high in every other state;
// done is a single-cycle pulse in the DONE state and result is valid then and
// holds until the next done; kill aborts CALC/FIX/DONE without a done pulse.
module rv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2:0]        fn;
  logic [XLEN-1:0]   mag_a;    // multiplicand / dividend magnitude
  logic [XLEN-1:0]   mag_b;    // divisor magnitude
  logic [XLEN-1:0]   quo;      // dividend shifts out, quotient shifts in
  logic [2*XLEN-1:0] prod;     // high half accumulates, low half holds multiplier
  logic [XLEN:0]     rem;      // partial remainder
  logic              neg_res;  // product / quotient sign
  logic              neg_rem;  // remainder sign follows dividend

  // Accept-time operand preparation
  logic            a_sgn, b_sgn, div_zero, ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_val;

  // Per-step datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !kill;
  assign dbg_state = state;

  // Operand signs, magnitudes and the special-case shortcut value
  always_comb begin
    a_sgn    = 1'b0;
    b_sgn    = 1'b0;
    spec_val = '0;
    if (funct3 == F_MULH || funct3 == F_MULHSU || funct3 == F_DIV || funct3 == F_REM)
      a_sgn = op_a[XLEN-1];
    if (funct3 == F_MULH || funct3 == F_DIV || funct3 == F_REM)
      b_sgn = op_b[XLEN-1];
    abs_a    = a_sgn ? -op_a : op_a;
    abs_b    = b_sgn ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    ovf      = (funct3 == F_DIV || funct3 == F_REM) && (op_a == MOST_NEG) && (op_b == '1);
    special  = div_zero || ovf;
    if (div_zero)
      spec_val = funct3[1] ? op_a : '1;
    else if (ovf)
      spec_val = funct3[1] ? '0 : op_a;
  end

  // One shift-add or restoring-divide step, plus final sign correction
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem[XLEN-1:0], quo[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    div_ok    = !div_diff[XLEN+1];
    prod_fix  = neg_res ? -prod : prod;
    quo_fix   = neg_res ? -quo : quo;
    rem_fix   = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    fix_val   = '0;
    case (fn)
      F_MUL:                     fix_val = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             fix_val = quo_fix;
      F_REM, F_REMU:             fix_val = rem_fix;
      default:                   fix_val = '0;
    endcase
  end

  // Next-state logic; kill outranks every transition outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == CW'(XLEN-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill && state != IDLE)
      state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers: latch on accept, iterate in CALC, load result in FIX
  always_ff @(posedge clk) begin
    if (!nRst) begin
      cnt     <= '0;
      fn      <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      quo     <= '0;
      prod    <= '0;
      rem     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          fn      <= funct3;
          mag_a   <= abs_a;
          mag_b   <= abs_b;
          quo     <= abs_a;
          prod    <= {{XLEN{1'b0}}, abs_b};
          rem     <= '0;
          cnt     <= '0;
          neg_res <= a_sgn ^ b_sgn;
          neg_rem <= a_sgn;
          if (special) result <= spec_val;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (fn[2]) begin
            rem <= div_ok ? div_diff[XLEN:0] : div_shift;
            quo <= {quo[XLEN-2:0], div_ok};
          end else begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end
        end
        FIX: if (!kill) result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed vectors for the iterative mul/div unit (XLEN=32).
// Driver tasks push the hand-computed result into exp_q; an independent
// monitor pops and compares on every done pulse.
module tb_rv_muldiv_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         nrst;
  logic         start, kill;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(W)) dut (
    .clk(clk), .nRst(nrst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (nrst && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else                   chk("result", result, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the unit idle; returns at a negedge, unit idle.
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat);
    int lat;
    bit busy_ok;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    exp_q.push_back(exp);
    last_exp = exp;
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    lat = 1; busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_held", 32'(busy_ok & busy), 32'd1);
    @(negedge clk);
    chk("idle_after", {30'd0, busy, done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    nrst = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {29'd0, busy, done, |result}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Multiply family
    run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
    run_op(3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 34);
    run_op(3'b000, 32'h00012345, 32'h00010000, 32'h23450000, 34);

    // Divide family
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34);
    run_op(3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 34);
    run_op(3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    run_op(3'b110, 32'd7, 32'hFFFFFFFE, 32'h00000001, 34);
    run_op(3'b100, 32'h80000000, 32'd1, 32'h80000000, 34);

    // Special cases finish one cycle after accept
    run_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op(3'b111, 32'd5,        32'd0,        32'h00000005, 1);
    run_op(3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // start held high with new operands while busy: ignored
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFFFFFD; start = 1'b1;
    exp_q.push_back(32'hFFFFFFEB);
    last_exp = 32'hFFFFFFEB;
    @(negedge clk);
    op_a = 32'd5; op_b = 32'd5; funct3 = 3'b011;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("held_start_latency", 32'(lat), 32'd34);
    @(negedge clk);
    start = 1'b0;
    chk("held_start_idle", {30'd0, busy, done}, 32'd0);
    repeat (4) @(negedge clk);
    chk("held_start_no_rerun", {30'd0, busy, done}, 32'd0);

    // kill in the 10th CALC cycle of a DIV
    funct3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("kill_pre_busy", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_idle", {30'd0, busy, done}, 32'd0);
    chk("kill_result_hold", result, last_exp);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 34);

    // synchronous reset mid-CALC
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("midrst_outputs", {30'd0, busy, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    run_op(3'b011, 32'd3, 32'd5, 32'd0, 34);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
